bcd_countdown_hms: RTL and testbench

//   BCD down-counter HH:MM:SS for the PengTimer countdown function: the counting-down counterpart of the
//   up-counting hour/minute/second chain. Loaded with a preset time, decrements once per 1 Hz tick while

---
 rtl/bcd_countdown_hms.sv | 217 +++++++++++++++++++++
 tb/tb_bcd_countdown_hms.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_hms.sv
// rtl/bcd_countdown_hms.sv - BCD HH:MM:SS countdown timer with preset load, pause/resume and expiry alarm
//
// Purpose
//   Counts a loaded HH:MM:SS preset down by one second per tick_i while
//   running. On reaching 00:00:00 it pulses done_o, then either raises
//   alarm_o (EXPIRED) or, with AUTO_RELOAD, reloads the preset and keeps
//   running.
//
// Parameters
//   HOUR_MAX     largest loadable hours value (1..99); larger loads are rejected
//   AUTO_RELOAD  1: on expiry reload the last accepted preset and keep running
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   tick_i              1 Hz enable, one clk wide
//   load_i              pulse: capture ld_*_i as preset and count
//   ld_{h1..s0}_i       preset BCD digits (tens/ones of hours, minutes, seconds)
//   start_i             pulse: begin/resume counting
//   pause_i             pulse: suspend counting
//   ack_i               pulse: clear alarm, return to idle
//   {h1..s0}_o          current count, BCD, registered
//   running_o           high while counting
//   done_o              one-cycle pulse on expiry
//   alarm_o             high while expired
//   load_err_o          one-cycle pulse after a rejected load

module bcd_countdown_hms #(
  parameter int unsigned HOUR_MAX    = 23,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [3:0] ld_h1_i,
  input  logic [3:0] ld_h0_i,
  input  logic [3:0] ld_m1_i,
  input  logic [3:0] ld_m0_i,
  input  logic [3:0] ld_s1_i,
  input  logic [3:0] ld_s0_i,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       ack_i,
  output logic [3:0] h1_o,
  output logic [3:0] h0_o,
  output logic [3:0] m1_o,
  output logic [3:0] m0_o,
  output logic [3:0] s1_o,
  output logic [3:0] s0_o,
  output logic       running_o,
  output logic       done_o,
  output logic       alarm_o,
  output logic       load_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [7:0] HOUR_MAX_B = 8'(HOUR_MAX);

  // Digit index 5..0 = h1, h0, m1, m0, s1, s0.
  state_e          state_q,    state_d;
  logic [5:0][3:0] cnt_q,      cnt_d;
  logic [5:0][3:0] preset_q,   preset_d;
  logic            done_q,     done_d;
  logic            load_err_q, load_err_d;
  // Set on an auto-reload expiry; the preset is copied in on the next
  // tick-free cycle so the zero count is visible for the done cycle.
  logic            reload_q,   reload_d;

  logic [5:0][3:0] ld_vec;
  logic [7:0]      ld_hours;
  logic            load_ok;
  logic            cnt_zero;
  logic            cnt_one;
  logic            preset_zero;
  logic [5:0][3:0] dec_cnt;
  logic            borrow;

  // Load validation
  always_comb begin
    ld_vec   = {ld_h1_i, ld_h0_i, ld_m1_i, ld_m0_i, ld_s1_i, ld_s0_i};
    ld_hours = ({4'd0, ld_h1_i} * 8'd10) + {4'd0, ld_h0_i};
    load_ok  = (ld_h1_i <= 4'd9) && (ld_h0_i <= 4'd9) &&
               (ld_m1_i <= 4'd5) && (ld_m0_i <= 4'd9) &&
               (ld_s1_i <= 4'd5) && (ld_s0_i <= 4'd9) &&
               (ld_hours <= HOUR_MAX_B);
  end

  always_comb begin
    cnt_zero    = (cnt_q == 24'h000000);
    cnt_one     = (cnt_q == 24'h000001);
    preset_zero = (preset_q == 24'h000000);
  end

  // One-second decrement with BCD borrow chain. Tens of minutes and tens of
  // seconds wrap to 5, all other digits to 9. Only used when count != 0, so
  // the hour tens digit never has to wrap.
  always_comb begin
    dec_cnt = cnt_q;
    borrow  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (cnt_q[i] != 4'd0) begin
          dec_cnt[i] = cnt_q[i] - 4'd1;
          borrow     = 1'b0;
        end else begin
          dec_cnt[i] = ((i == 1) || (i == 3)) ? 4'd5 : 4'd9;
        end
      end
    end
  end

  // Next-state logic. Priority: load > ack > pause > start > tick.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    preset_d   = preset_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    reload_d   = reload_q;

    if (load_i && load_ok) begin
      // An accepted load overrides everything else in this cycle.
      preset_d = ld_vec;
      cnt_d    = ld_vec;
      state_d  = ST_IDLE;
      reload_d = 1'b0;
    end else begin
      // A rejected load changes nothing but still lets other inputs act.
      if (load_i) begin
        load_err_d = 1'b1;
      end

      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (!ack_i && !pause_i && start_i && !cnt_zero) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (ack_i) begin
            state_d  = ST_IDLE;
            reload_d = 1'b0;
          end else begin
            if (reload_q) begin
              if (!tick_i || pause_i) begin
                cnt_d    = preset_q;
                reload_d = 1'b0;
              end
            end else if (!pause_i && tick_i && !cnt_zero) begin
              cnt_d = dec_cnt;
              if (cnt_one) begin
                done_d = 1'b1;
                if (AUTO_RELOAD && !preset_zero) begin
                  reload_d = 1'b1;
                end else begin
                  state_d = ST_EXPIRED;
                end
              end
            end
            // A tick coinciding with pause is discarded above.
            if (pause_i) begin
              state_d = ST_PAUSE;
            end
          end
        end

        ST_EXPIRED: begin
          if (ack_i) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      preset_q   <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      reload_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      preset_q   <= preset_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
      reload_q   <= reload_d;
    end
  end

  assign h1_o       = cnt_q[5];
  assign h0_o       = cnt_q[4];
  assign m1_o       = cnt_q[3];
  assign m0_o       = cnt_q[2];
  assign s1_o       = cnt_q[1];
  assign s0_o       = cnt_q[0];
  assign running_o  = (state_q == ST_RUN);
  assign alarm_o    = (state_q == ST_EXPIRED);
  assign done_o     = done_q;
  assign load_err_o = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_hms.sv
// tb/tb_bcd_countdown_hms.sv - directed scoreboard bench for the BCD HH:MM:SS countdown timer

module tb_bcd_countdown_hms;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] ld_h1 = '0, ld_h0 = '0, ld_m1 = '0, ld_m0 = '0, ld_s1 = '0, ld_s0 = '0;

  logic tick_a = 0, load_a = 0, start_a = 0, pause_a = 0, ack_a = 0;
  logic tick_b = 0, load_b = 0, start_b = 0, pause_b = 0, ack_b = 0;

  logic [3:0] h1_a, h0_a, m1_a, m0_a, s1_a, s0_a;
  logic       run_a, done_a, alarm_a, lerr_a;
  logic [3:0] h1_b, h0_b, m1_b, m0_b, s1_b, s0_b;
  logic       run_b, done_b, alarm_b, lerr_b;

  bcd_countdown_hms #(.HOUR_MAX(23), .AUTO_RELOAD(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_a), .load_i(load_a),
    .ld_h1_i(ld_h1), .ld_h0_i(ld_h0), .ld_m1_i(ld_m1), .ld_m0_i(ld_m0),
    .ld_s1_i(ld_s1), .ld_s0_i(ld_s0),
    .start_i(start_a), .pause_i(pause_a), .ack_i(ack_a),
    .h1_o(h1_a), .h0_o(h0_a), .m1_o(m1_a), .m0_o(m0_a), .s1_o(s1_a), .s0_o(s0_a),
    .running_o(run_a), .done_o(done_a), .alarm_o(alarm_a), .load_err_o(lerr_a)
  );

  bcd_countdown_hms #(.HOUR_MAX(23), .AUTO_RELOAD(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_b), .load_i(load_b),
    .ld_h1_i(ld_h1), .ld_h0_i(ld_h0), .ld_m1_i(ld_m1), .ld_m0_i(ld_m0),
    .ld_s1_i(ld_s1), .ld_s0_i(ld_s0),
    .start_i(start_b), .pause_i(pause_b), .ack_i(ack_b),
    .h1_o(h1_b), .h0_o(h0_b), .m1_o(m1_b), .m0_o(m0_b), .s1_o(s1_b), .s0_o(s0_b),
    .running_o(run_b), .done_o(done_b), .alarm_o(alarm_b), .load_err_o(lerr_b)
  );

  logic [27:0] obs_a, obs_b;
  assign obs_a = {h1_a, h0_a, m1_a, m0_a, s1_a, s0_a, run_a, done_a, alarm_a, lerr_a};
  assign obs_b = {h1_b, h0_b, m1_b, m0_b, s1_b, s0_b, run_b, done_b, alarm_b, lerr_b};

  typedef struct {
    string       tag;
    bit          which;
    logic [27:0] val;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // Expected observation: time as BCD hex 0xHHMMSS plus running/done/alarm/load_err.
  function automatic logic [27:0] mk(input logic [23:0] t, input logic r, input logic d,
                                     input logic a, input logic e);
    return {t, r, d, a, e};
  endfunction

  task automatic push(input string tag, input bit which, input logic [27:0] v);
    exp_t e;
    e.tag   = tag;
    e.which = which;
    e.val   = v;
    sbq.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [27:0] o;
    e = sbq.pop_front();
    o = e.which ? obs_b : obs_a;
    total++;
    assert (o === e.val) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
    end
  endtask

  task automatic setld(input logic [23:0] v);
    {ld_h1, ld_h0, ld_m1, ld_m0, ld_s1, ld_s0} = v;
  endtask

  // Pulses are set by the caller, held across one rising edge, then cleared;
  // the outputs are sampled 1 time unit after that edge.
  task automatic cyc(input string tag, input bit which, input logic [27:0] v);
    push(tag, which, v);
    @(posedge clk);
    #1;
    {tick_a, load_a, start_a, pause_a, ack_a} = '0;
    {tick_b, load_b, start_b, pause_b, ack_b} = '0;
    check();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push("reset_a", 0, mk(24'h000000, 0, 0, 0, 0)); check();
    push("reset_b", 1, mk(24'h000000, 0, 0, 0, 0)); check();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic countdown to expiry, alarm and acknowledge
    setld(24'h000003); load_a = 1;
    cyc("load_3s",      0, mk(24'h000003, 0, 0, 0, 0));
    start_a = 1; cyc("start",        0, mk(24'h000003, 1, 0, 0, 0));
    tick_a  = 1; cyc("tick1",        0, mk(24'h000002, 1, 0, 0, 0));
    tick_a  = 1; cyc("tick2",        0, mk(24'h000001, 1, 0, 0, 0));
    tick_a  = 1; cyc("tick3_done",   0, mk(24'h000000, 0, 1, 1, 0));
    tick_a  = 1; cyc("expired_hold", 0, mk(24'h000000, 0, 0, 1, 0));
    ack_a   = 1; cyc("ack",          0, mk(24'h000000, 0, 0, 0, 0));
    start_a = 1; cyc("start_zero",   0, mk(24'h000000, 0, 0, 0, 0));

    // Full borrow chains
    setld(24'h010000); load_a = 1;
    cyc("load_1h",      0, mk(24'h010000, 0, 0, 0, 0));
    start_a = 1; cyc("start_1h",     0, mk(24'h010000, 1, 0, 0, 0));
    tick_a  = 1; cyc("borrow_1h",    0, mk(24'h005959, 1, 0, 0, 0));
    setld(24'h100000); load_a = 1;
    cyc("load_10h_run", 0, mk(24'h100000, 0, 0, 0, 0));
    start_a = 1; cyc("start_10h",    0, mk(24'h100000, 1, 0, 0, 0));
    tick_a  = 1; cyc("borrow_10h",   0, mk(24'h095959, 1, 0, 0, 0));

    // Rejected loads
    setld(24'h000060); load_a = 1;
    cyc("bad_s1",       0, mk(24'h095959, 1, 0, 0, 1));
    cyc("bad_s1_clr",   0, mk(24'h095959, 1, 0, 0, 0));
    setld(24'h240000); load_a = 1;
    cyc("bad_hours",    0, mk(24'h095959, 1, 0, 0, 1));
    setld(24'h230000); load_a = 1; tick_a = 1;
    cyc("max_hours",    0, mk(24'h230000, 0, 0, 0, 0));
    start_a = 1; cyc("start_23h",    0, mk(24'h230000, 1, 0, 0, 0));
    tick_a  = 1; cyc("tick_23h",     0, mk(24'h225959, 1, 0, 0, 0));

    // Pause with coincident tick, resume
    pause_a = 1; tick_a = 1;
    cyc("pause_tick",   0, mk(24'h225959, 0, 0, 0, 0));
    tick_a  = 1; cyc("tick_paused",  0, mk(24'h225959, 0, 0, 0, 0));
    ack_a   = 1; cyc("ack_paused",   0, mk(24'h225959, 0, 0, 0, 0));
    start_a = 1; cyc("resume",       0, mk(24'h225959, 1, 0, 0, 0));
    tick_a  = 1; cyc("tick_resumed", 0, mk(24'h225958, 1, 0, 0, 0));

    // Load and tick in the same cycle while running
    setld(24'h001234); load_a = 1; tick_a = 1;
    cyc("load_vs_tick", 0, mk(24'h001234, 0, 0, 0, 0));
    tick_a  = 1; cyc("tick_idle",    0, mk(24'h001234, 0, 0, 0, 0));
    start_a = 1; cyc("start_1234",   0, mk(24'h001234, 1, 0, 0, 0));
    tick_a  = 1; cyc("tick_1234",    0, mk(24'h001233, 1, 0, 0, 0));

    // Auto-reload instance
    setld(24'h000002); load_b = 1;
    cyc("ar_load",      1, mk(24'h000002, 0, 0, 0, 0));
    start_b = 1; cyc("ar_start",     1, mk(24'h000002, 1, 0, 0, 0));
    tick_b  = 1; cyc("ar_tick1",     1, mk(24'h000001, 1, 0, 0, 0));
    tick_b  = 1; cyc("ar_done",      1, mk(24'h000000, 1, 1, 0, 0));
    cyc("ar_reload",    1, mk(24'h000002, 1, 0, 0, 0));
    tick_b  = 1; cyc("ar_tick_again",1, mk(24'h000001, 1, 0, 0, 0));

    // Asynchronous reset mid-count, preset lost
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    push("async_rst_a", 0, mk(24'h000000, 0, 0, 0, 0)); check();
    push("async_rst_b", 1, mk(24'h000000, 0, 0, 0, 0)); check();
    @(negedge clk);
    rst_n = 1'b1;
    start_a = 1; cyc("start_after_rst", 0, mk(24'h000000, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
